// File: rtl/ctc_timing_gen.sv
// Bit-time counter, instruction deserialiser, digit pointer, word-select decode
// and debounced key-matrix scanner for the Eris control-and-timing chip.
module ctc_timing_gen #(
  parameter int DIGITS  = 14,
  parameter int DBITS   = 4,
  parameter int XDIGITS = 2,
  parameter int KR_N    = 8,
  parameter int KC_N    = 5,
  parameter int DEB     = 2,
  localparam int WT     = DIGITS * DBITS,
  localparam int CW     = $clog2(WT)
) (
  input  logic            i_cph2,
  input  logic            i_pon,
  input  logic            i_is,
  input  logic [KC_N-1:0] i_kc,
  input  logic            i_key_ack,
  output logic            o_sync,
  output logic            o_ws,
  output logic [KR_N-1:0] o_kr,
  output logic            o_key_valid,
  output logic [CW-1:0]   o_key_code,
  output logic [3:0]      o_ptr
);

  logic [CW-1:0] r_cnt;
  logic [9:0]    r_ibuf;
  logic [3:0]    r_ptr;
  logic          r_fen;
  logic [2:0]    r_field;
  logic          r_hit;
  logic [CW-1:0] r_hcode;
  logic [CW-1:0] r_lcode;
  logic [2:0]    r_dcnt;
  logic          r_reported;
  logic          r_key_valid;
  logic [CW-1:0] r_key_code;

  logic          w_eow;
  int            w_digit;
  logic          w_hit;
  logic          w_any;
  logic [CW-1:0] w_code;
  logic [CW-1:0] w_lcode_nxt;
  logic [2:0]    w_dcnt_nxt;
  logic          w_report;
  logic [3:0]    w_ptr_nxt;
  logic          w_in_field;

  always_comb begin
    w_eow   = (r_cnt == CW'(WT - 1));
    w_digit = int'(r_cnt) / DBITS;
    o_sync  = (int'(r_cnt) >= WT - 11) && (int'(r_cnt) <= WT - 2);

    o_kr  = '0;
    w_hit = 1'b0;
    for (int j = 0; j < KR_N; j++) begin
      if ((int'(r_cnt) % KR_N) == j) o_kr[j] = 1'b1;
    end
    // A column only counts while its own group of row strobes is active.
    for (int j = 0; j < KC_N; j++) begin
      if (((int'(r_cnt) / KR_N) == j) && i_kc[j]) w_hit = 1'b1;
    end

    w_any       = r_hit | w_hit;
    w_code      = r_hit ? r_hcode : r_cnt;
    w_lcode_nxt = r_lcode;
    w_dcnt_nxt  = r_dcnt;
    if (w_any) begin
      if (w_code == r_lcode) begin
        if (r_dcnt < 3'(DEB)) w_dcnt_nxt = r_dcnt + 3'd1;
      end else begin
        w_dcnt_nxt  = 3'd1;
        w_lcode_nxt = w_code;
      end
    end else begin
      w_dcnt_nxt = 3'd0;
    end
    w_report = w_eow && w_any && (w_dcnt_nxt == 3'(DEB)) && !r_reported;

    w_ptr_nxt = r_ptr;
    if (r_ibuf[1:0] == 2'b00) begin
      if (r_ibuf[3:2] == 2'b11)
        w_ptr_nxt = (int'(r_ibuf[9:6]) >= DIGITS) ? 4'(DIGITS - 1) : r_ibuf[9:6];
      else if (r_ibuf[5:2] == 4'b0110)
        w_ptr_nxt = (int'(r_ptr) == DIGITS - 1) ? 4'd0 : r_ptr + 4'd1;
      else if (r_ibuf[5:2] == 4'b0010)
        w_ptr_nxt = (r_ptr == 4'd0) ? 4'(DIGITS - 1) : r_ptr - 4'd1;
    end

    case (r_field)
      3'd0:    w_in_field = (w_digit == int'(r_ptr));
      3'd1:    w_in_field = (w_digit <= int'(r_ptr));
      3'd2:    w_in_field = (w_digit < XDIGITS);
      3'd3:    w_in_field = 1'b1;
      3'd4:    w_in_field = (w_digit >= XDIGITS + 1) && (w_digit <= DIGITS - 2);
      3'd5:    w_in_field = (w_digit >= XDIGITS + 1) && (w_digit <= DIGITS - 1);
      3'd6:    w_in_field = (w_digit == XDIGITS);
      default: w_in_field = (w_digit == DIGITS - 1);
    endcase
    o_ws = r_fen && w_in_field;
  end

  always_ff @(posedge i_cph2) begin
    if (i_pon) begin
      r_cnt       <= '0;
      r_ibuf      <= '0;
      r_ptr       <= '0;
      r_fen       <= 1'b0;
      r_field     <= '0;
      r_hit       <= 1'b0;
      r_hcode     <= '0;
      r_lcode     <= '0;
      r_dcnt      <= '0;
      r_reported  <= 1'b0;
      r_key_valid <= 1'b0;
      r_key_code  <= '0;
    end else begin
      r_cnt <= w_eow ? '0 : r_cnt + CW'(1);
      if (o_sync) r_ibuf <= {i_is, r_ibuf[9:1]};
      if (w_eow) begin
        r_ptr  <= w_ptr_nxt;
        r_fen  <= (r_ibuf[1:0] == 2'b10);
        if (r_ibuf[1:0] == 2'b10) r_field <= r_ibuf[4:2];
        r_hit   <= 1'b0;
        r_dcnt  <= w_dcnt_nxt;
        r_lcode <= w_lcode_nxt;
        if (!w_any) r_reported <= 1'b0;
        else if (w_report) r_reported <= 1'b1;
      end else if (w_hit && !r_hit) begin
        // Lowest code in the word wins; later hits are ignored.
        r_hit   <= 1'b1;
        r_hcode <= r_cnt;
      end
      if (w_report) begin
        r_key_valid <= 1'b1;
        r_key_code  <= w_lcode_nxt;
      end else if (i_key_ack) begin
        r_key_valid <= 1'b0;
      end
    end
  end

  assign o_key_valid = r_key_valid;
  assign o_key_code  = r_key_code;
  assign o_ptr       = r_ptr;

endmodule

// File: tb/tb_ctc_timing_gen.sv
// Scoreboard bench for ctc_timing_gen: a word-level reference model predicts every
// cycle's outputs into a queue, a negedge monitor pops and compares.
module tb_ctc_timing_gen;

  localparam int WT  = 56;
  localparam int DEB = 2;

  logic       cph2 = 1'b0;
  logic       pon, is_in, key_ack;
  logic [4:0] kc;
  logic       sync, ws, key_valid;
  logic [7:0] kr;
  logic [5:0] key_code;
  logic [3:0] ptr;

  ctc_timing_gen dut (
    .i_cph2(cph2), .i_pon(pon), .i_is(is_in), .i_kc(kc), .i_key_ack(key_ack),
    .o_sync(sync), .o_ws(ws), .o_kr(kr), .o_key_valid(key_valid),
    .o_key_code(key_code), .o_ptr(ptr)
  );

  always #5 cph2 = ~cph2;

  typedef struct {
    int         cnt;
    logic       sync;
    logic       ws;
    logic [7:0] kr;
    logic       kv;
    logic [5:0] kc;
    logic [3:0] ptr;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // word-level reference state
  int m_ptr, m_field, m_dcnt, m_last, m_kcode;
  bit m_fen, m_rep, m_kv;

  task automatic chk(input string nm, input int c, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s at cnt=%0d: got %0h, want %0h", nm, c, act, exp_v);
    end
  endtask

  always @(negedge cph2) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("sync",      e.cnt, int'(sync),      int'(e.sync));
      chk("ws",        e.cnt, int'(ws),        int'(e.ws));
      chk("kr",        e.cnt, int'(kr),        int'(e.kr));
      chk("key_valid", e.cnt, int'(key_valid), int'(e.kv));
      chk("key_code",  e.cnt, int'(key_code),  int'(e.kc));
      chk("ptr",       e.cnt, int'(ptr),       int'(e.ptr));
    end
  end

  function automatic bit in_field(int f, int d, int p);
    case (f)
      0: return d == p;
      1: return d <= p;
      2: return d < 2;
      3: return 1'b1;
      4: return d >= 3 && d <= 12;
      5: return d >= 3 && d <= 13;
      6: return d == 2;
      default: return d == 13;
    endcase
  endfunction

  function automatic logic [9:0] setp(int p);
    return 10'((p << 6) | 12);
  endfunction

  function automatic logic [9:0] fld(int f);
    return 10'((f << 2) | 2);
  endfunction

  task automatic do_reset(input int n);
    exp_t e;
    pon = 1'b1; key_ack = 1'b0; kc = '0; is_in = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge cph2); #1;
      if (i < n - 1) begin
        e.cnt = 0; e.sync = 1'b0; e.ws = 1'b0; e.kr = 8'h01;
        e.kv = 1'b0; e.kc = 6'd0; e.ptr = 4'd0;
        sb.push_back(e);
      end
    end
    pon = 1'b0;
    m_ptr = 0; m_field = 0; m_dcnt = 0; m_last = 0; m_kcode = 0;
    m_fen = 1'b0; m_rep = 1'b0; m_kv = 1'b0;
  endtask

  // One word time: keys k0/k1 (-1 = none) are pressed at their codes, ack pulses at
  // cnt ack_at, and abort_at (if >= 0) applies pon for rst_len cycles mid-word.
  task automatic run_word(input logic [9:0] instr, input int k0, input int k1,
                          input int ack_at, input int abort_at, input int rst_len);
    exp_t       e;
    logic [4:0] kcv;
    int         code;
    bit         rep;
    for (int c = 0; c < WT; c++) begin
      e.cnt  = c;
      e.sync = (c >= WT - 11) && (c <= WT - 2);
      e.kr   = 8'(1) << (c % 8);
      e.ws   = m_fen && in_field(m_field, c / 4, m_ptr);
      e.ptr  = 4'(m_ptr);
      e.kv   = m_kv && !(ack_at >= 0 && c > ack_at);
      e.kc   = 6'(m_kcode);
      sb.push_back(e);
      if (c == abort_at) begin
        do_reset(rst_len);
        return;
      end
      is_in = (c >= WT - 11 && c <= WT - 2) ? instr[c - (WT - 11)] : 1'($urandom);
      kcv = 5'($urandom);
      if (c / 8 < 5) kcv[c / 8] = (c == k0) || (c == k1);
      kc = kcv;
      key_ack = (c == ack_at);
      @(posedge cph2); #1;
    end
    key_ack = 1'b0;

    code = -1;
    if (k0 >= 0 && k0 < 40) code = k0;
    if (k1 >= 0 && k1 < 40 && (code < 0 || k1 < code)) code = k1;
    if (code >= 0) begin
      if (code == m_last) begin
        if (m_dcnt < DEB) m_dcnt = m_dcnt + 1;
      end else begin
        m_dcnt = 1;
        m_last = code;
      end
    end else begin
      m_dcnt = 0;
      m_rep  = 1'b0;
    end
    rep = (code >= 0) && (m_dcnt == DEB) && !m_rep;
    if (rep) begin
      m_rep = 1'b1; m_kv = 1'b1; m_kcode = m_last;
    end else if (ack_at >= 0) begin
      m_kv = 1'b0;
    end

    if (instr[1:0] == 2'b00) begin
      if (instr[3:2] == 2'b11)           m_ptr = (int'(instr[9:6]) > 13) ? 13 : int'(instr[9:6]);
      else if (instr[5:2] == 4'b0110)    m_ptr = (m_ptr + 1) % 14;
      else if (instr[5:2] == 4'b0010)    m_ptr = (m_ptr + 13) % 14;
    end
    m_fen = (instr[1:0] == 2'b10);
    if (m_fen) m_field = int'(instr[4:2]);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [9:0] ins;
    int         sel, ack, rk0, rk1, hold;
    pon = 1'b1; is_in = 1'b0; kc = '0; key_ack = 1'b0;
    do_reset(3);

    // directed: pointer ops, field sweep, key report / hold / ack / set-wins / glitch
    run_word(10'h000,  8, -1, -1, -1, 0);
    run_word(setp(4),  8, -1, -1, -1, 0);
    run_word(fld(1),   8, -1, -1, -1, 0);
    run_word(setp(13), 8, -1, 20, -1, 0);
    run_word(10'h018, -1, -1, -1, -1, 0);
    run_word(setp(0),  3, 17, -1, -1, 0);
    run_word(10'h008, 17,  3, -1, -1, 0);
    run_word(setp(15), -1, -1, -1, -1, 0);
    run_word(fld(4),   9, -1, -1, -1, 0);
    run_word(fld(5),   9, -1, 55, -1, 0);
    run_word(fld(2),  20, -1, 20, -1, 0);
    run_word(fld(6),  -1, -1, -1, -1, 0);
    run_word(fld(7),  -1, -1, -1, -1, 0);
    run_word(10'h3FF, -1, -1, -1, -1, 0);
    run_word(10'h000, -1, -1, -1, -1, 0);
    run_word(10'h000, -1, -1, -1, -1, 0);

    // mid-word resets, single-cycle and held
    run_word(setp(7),  5, -1, -1, -1, 0);
    run_word(fld(3),   5, -1, -1, 30, 1);
    run_word(fld(3),  -1, -1, -1, -1, 0);
    run_word(10'h000, 12, -1, -1, 30, 3);
    run_word(10'h000, -1, -1, -1, -1, 0);

    hold = 0; rk0 = -1; rk1 = -1;
    for (int w = 0; w < 250; w++) begin
      sel = int'($urandom_range(0, 5));
      case (sel)
        0:       ins = setp(int'($urandom_range(0, 15)));
        1:       ins = 10'h018;
        2:       ins = 10'h008;
        3, 4:    ins = fld(int'($urandom_range(0, 7)));
        default: ins = 10'($urandom);
      endcase
      if (hold == 0) begin
        if ($urandom_range(0, 9) < 4) begin
          rk0 = -1; rk1 = -1;
          hold = int'($urandom_range(1, 2));
        end else begin
          rk0 = int'($urandom_range(0, 39));
          rk1 = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 39)) : -1;
          hold = int'($urandom_range(1, 4));
        end
      end
      hold = hold - 1;
      sel = int'($urandom_range(0, 7));
      ack = (sel == 0) ? 20 : (sel == 1) ? 55 : (sel == 2) ? int'($urandom_range(0, 55)) : -1;
      run_word(ins, rk0, rk1, ack, -1, 0);
    end

    @(negedge cph2);
    @(negedge cph2);
    chk("sb_drain", 0, sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
